tlut_psum_collector: RTL and testbench

// - Downstream of simd_cell. Captures its DIM_A product_acc lanes once per tile.
// - Accumulates those lanes over a programmed number of K-tiles.
// - Drains the finished sums one lane per beat on a valid/ready stream to the output buffer.

---
 rtl/tlut_pkg.sv | 19 +
 rtl/tlut_psum_collector_if.sv | 28 ++
 rtl/tlut_lane_acc.sv | 64 ++++++
 rtl/tlut_psum_collector.sv | 141 ++++++++++++++
 tb/tb_tlut_psum_collector.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlut_pkg.sv
// Shared types and default sizing for the TLUT partial-sum collector.
// Optional build macro used by the collector files: TLUT_PSUM_SAT_EN.
package tlut_pkg;

  localparam int DIM_A     = 9;
  localparam int ACC_WIDTH = 13;
  localparam int OUT_WIDTH = 20;
  localparam int TILE_W    = 5;
  localparam int LANE_W    = $clog2(DIM_A);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } coll_state_e;

  typedef logic [DIM_A-1:0][ACC_WIDTH-1:0] prod_vec_t;

endpackage

// File: rtl/tlut_psum_collector_if.sv
// Output drain stream of the partial-sum collector: one lane sum per beat, valid/ready.
interface tlut_psum_collector_if
  import tlut_pkg::*;
#(
  parameter int OUT_WIDTH = tlut_pkg::OUT_WIDTH,
  parameter int LANE_W    = tlut_pkg::LANE_W
);

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [LANE_W-1:0]    out_lane;

  modport master (
    output out_valid,
    output out_data,
    output out_lane,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_lane,
    output out_ready
  );

endinterface

// File: rtl/tlut_lane_acc.sv
// One lane accumulator register; wraps by default, saturates when TLUT_PSUM_SAT_EN is defined.
module tlut_lane_acc
  import tlut_pkg::*;
#(
  parameter int ACC_WIDTH = tlut_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = tlut_pkg::OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [ACC_WIDTH-1:0] operand,
`ifdef TLUT_PSUM_SAT_EN
  output logic                 sat,
`endif
  output logic [OUT_WIDTH-1:0] sum,
  output logic [OUT_WIDTH-1:0] sum_nxt
);

  logic [OUT_WIDTH-1:0] add_res;

`ifdef TLUT_PSUM_SAT_EN
  function automatic logic [OUT_WIDTH:0] lane_add_wide(input logic [OUT_WIDTH-1:0] a,
                                                       input logic [ACC_WIDTH-1:0] b);
    return {1'b0, a} + {{(OUT_WIDTH + 1 - ACC_WIDTH){1'b0}}, b};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] lane_sat(input logic [OUT_WIDTH:0] s);
    return s[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : s[OUT_WIDTH-1:0];
  endfunction

  logic [OUT_WIDTH:0] wide_sum;

  assign wide_sum = lane_add_wide(sum, operand);
  assign add_res  = lane_sat(wide_sum);
  assign sat      = wide_sum[OUT_WIDTH];
`else
  function automatic logic [OUT_WIDTH-1:0] lane_add_wrap(input logic [OUT_WIDTH-1:0] a,
                                                         input logic [ACC_WIDTH-1:0] b);
    return a + {{(OUT_WIDTH - ACC_WIDTH){1'b0}}, b};
  endfunction

  assign add_res = lane_add_wrap(sum, operand);
`endif

  // clear wins over add so a run always starts from zero
  always_comb begin
    sum_nxt = sum;
    if (clr) begin
      sum_nxt = '0;
    end else if (add_en) begin
      sum_nxt = add_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else begin
      sum <= sum_nxt;
    end
  end

endmodule

// File: rtl/tlut_psum_collector.sv
// Accumulates simd_cell product lanes over K-tiles, then drains one lane sum per beat.
// Build option TLUT_PSUM_SAT_EN: saturating lane adds plus sticky sat_flag output.
module tlut_psum_collector
  import tlut_pkg::*;
#(
  parameter int DIM_A     = tlut_pkg::DIM_A,
  parameter int ACC_WIDTH = tlut_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = tlut_pkg::OUT_WIDTH,
  parameter int TILE_W    = tlut_pkg::TILE_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [TILE_W-1:0]                   num_tiles,
  input  logic                                prod_valid,
  input  logic [DIM_A-1:0][ACC_WIDTH-1:0]     product_acc,
  tlut_psum_collector_if.master               out_if,
`ifdef TLUT_PSUM_SAT_EN
  output logic                                sat_flag,
`endif
  output logic                                busy,
  output logic                                done,
  output logic                                drop_err
);

  localparam int LANE_W = $clog2(DIM_A);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]           state;
  logic [TILE_W-1:0]    tile_cnt;
  logic [TILE_W-1:0]    tiles_tgt;
  logic [LANE_W-1:0]    lane;
  logic [LANE_W-1:0]    lane_nxt;
  logic [OUT_WIDTH-1:0] sum_p0  [DIM_A];
  logic [OUT_WIDTH-1:0] sum_nxt [DIM_A];
  logic                 take_start;
  logic                 take_prod;
  logic                 last_tile;
  logic                 accept;
  logic                 last_beat;
`ifdef TLUT_PSUM_SAT_EN
  logic [DIM_A-1:0]     lane_sat;
`endif

  assign take_start = (state == ST_IDLE) && start;
  assign take_prod  = (state == ST_ACCUM) && prod_valid;
  assign last_tile  = take_prod && ((tile_cnt + TILE_W'(1)) == tiles_tgt);
  assign accept     = out_if.out_valid && out_if.out_ready;
  assign lane_nxt   = lane + LANE_W'(1);
  assign last_beat  = accept && (lane == LANE_W'(DIM_A - 1));
  assign busy       = (state != ST_IDLE);
  assign out_if.out_lane = lane;

  for (genvar i = 0; i < DIM_A; i++) begin : g_lane
    tlut_lane_acc #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .clr     (take_start),
      .add_en  (take_prod),
      .operand (product_acc[i]),
`ifdef TLUT_PSUM_SAT_EN
      .sat     (lane_sat[i]),
`endif
      .sum     (sum_p0[i]),
      .sum_nxt (sum_nxt[i])
    );
  end

  // first beat takes lane 0 from the adder output so DRAIN starts with the final sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      tile_cnt         <= '0;
      tiles_tgt        <= '0;
      lane             <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      done             <= 1'b0;
      drop_err         <= 1'b0;
`ifdef TLUT_PSUM_SAT_EN
      sat_flag         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACCUM;
            tile_cnt  <= '0;
            tiles_tgt <= (num_tiles == '0) ? TILE_W'(1) : num_tiles;
            drop_err  <= 1'b0;
`ifdef TLUT_PSUM_SAT_EN
            sat_flag  <= 1'b0;
`endif
          end else if (prod_valid) begin
            drop_err <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (prod_valid) begin
            tile_cnt <= tile_cnt + TILE_W'(1);
`ifdef TLUT_PSUM_SAT_EN
            if (|lane_sat) begin
              sat_flag <= 1'b1;
            end
`endif
            if (last_tile) begin
              state            <= ST_DRAIN;
              lane             <= '0;
              out_if.out_valid <= 1'b1;
              out_if.out_data  <= sum_nxt[0];
            end
          end
        end
        ST_DRAIN: begin
          if (prod_valid) begin
            drop_err <= 1'b1;
          end
          if (last_beat) begin
            state            <= ST_IDLE;
            out_if.out_valid <= 1'b0;
            done             <= 1'b1;
          end else if (accept) begin
            lane            <= lane_nxt;
            out_if.out_data <= sum_p0[lane_nxt];
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlut_psum_collector.sv
// Randomized bench for tlut_psum_collector: a 20-bit and a 13-bit instance share stimulus
// and are checked against per-lane running totals kept in the bench.
module tb_tlut_psum_collector;
  import tlut_pkg::*;

  localparam int OW_S = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [TILE_W-1:0] num_tiles;
  logic        prod_valid;
  prod_vec_t   product_acc;
  logic        busy, done, drop_err;
  logic        busy_s, done_s, drop_err_s;
`ifdef TLUT_PSUM_SAT_EN
  logic        sat_flag, sat_flag_s;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  longint tot [DIM_A];

  tlut_psum_collector_if #(.OUT_WIDTH(OUT_WIDTH), .LANE_W(LANE_W)) bus ();
  tlut_psum_collector_if #(.OUT_WIDTH(OW_S),      .LANE_W(LANE_W)) bus_s ();

  always #5 clk = ~clk;

  tlut_psum_collector dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_tiles   (num_tiles),
    .prod_valid  (prod_valid),
    .product_acc (product_acc),
    .out_if      (bus),
`ifdef TLUT_PSUM_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .busy        (busy),
    .done        (done),
    .drop_err    (drop_err)
  );

  tlut_psum_collector #(.OUT_WIDTH(OW_S)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_tiles   (num_tiles),
    .prod_valid  (prod_valid),
    .product_acc (product_acc),
    .out_if      (bus_s),
`ifdef TLUT_PSUM_SAT_EN
    .sat_flag    (sat_flag_s),
`endif
    .busy        (busy_s),
    .done        (done_s),
    .drop_err    (drop_err_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_main(input int i);
    longint m;
    m = longint'(1) << OUT_WIDTH;
    return 32'(tot[i] % m);
  endfunction

  function automatic logic [31:0] exp_small(input int i);
    longint m;
    m = longint'(1) << OW_S;
`ifdef TLUT_PSUM_SAT_EN
    return (tot[i] >= m) ? 32'(m - 1) : 32'(tot[i]);
`else
    return 32'(tot[i] % m);
`endif
  endfunction

  function automatic logic any_over_small();
    logic f;
    f = 1'b0;
    for (int i = 0; i < DIM_A; i++) if (tot[i] >= (longint'(1) << OW_S)) f = 1'b1;
    return f;
  endfunction

  function automatic prod_vec_t rand_prod();
    prod_vec_t p;
    for (int i = 0; i < DIM_A; i++) begin
      if ($urandom_range(0, 3) == 0) p[i] = '1;
      else p[i] = ACC_WIDTH'($urandom);
    end
    return p;
  endfunction

  function automatic prod_vec_t all_max();
    prod_vec_t p;
    for (int i = 0; i < DIM_A; i++) p[i] = '1;
    return p;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DIM_A; i++) tot[i] = 0;
  endtask

  task automatic set_ready(input logic r);
    bus.out_ready   = r;
    bus_s.out_ready = r;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_tiles = TILE_W'(n);
    @(negedge clk);
    start = 1'b0;
    clear_model();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_drop_err", 32'(drop_err), 32'd0);
  endtask

  task automatic feed(input prod_vec_t p, input bit last);
    product_acc = p;
    prod_valid  = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    for (int i = 0; i < DIM_A; i++) tot[i] += longint'(p[i]);
    if (!last) begin
      chk("accum_valid_low", 32'(bus.out_valid), 32'd0);
      chk("accum_busy", 32'(busy), 32'd1);
    end
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input int mode);
    int   beat;
    int   cyc;
    logic rdy;
    logic held;
    logic [OUT_WIDTH-1:0] pd;
    logic [LANE_W-1:0]    pl;
    beat = 0;
    cyc  = 0;
    held = 1'b0;
    pd   = '0;
    pl   = '0;
    while (beat < DIM_A && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      chk("drain_busy", 32'(busy), 32'd1);
      if (held) begin
        chk("hold_lane", 32'(bus.out_lane), 32'(pl));
        chk("hold_data", 32'(bus.out_data), 32'(pd));
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (rdy) begin
          chk("beat_lane", 32'(bus.out_lane), 32'(beat));
          chk("beat_data", 32'(bus.out_data), exp_main(beat));
          chk("beat_data_13", 32'(bus_s.out_data), exp_small(beat));
          beat++;
        end else begin
          held = 1'b1;
          pl   = bus.out_lane;
          pd   = bus.out_data;
        end
      end
      set_ready(rdy);
      @(negedge clk);
      cyc++;
    end
    set_ready(1'b0);
    if (beat < DIM_A) chk("drain_timeout", 32'(beat), 32'(DIM_A));
    if (mode == 0) chk("drain_cycles", 32'(cyc), 32'(DIM_A));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_pulse_13", 32'(done_s), 32'd1);
    chk("end_valid", 32'(bus.out_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
`ifdef TLUT_PSUM_SAT_EN
    chk("sat_flag", 32'(sat_flag), 32'd0);
    chk("sat_flag_13", 32'(sat_flag_s), 32'(any_over_small()));
`endif
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
  endtask

  task automatic run(input int n, input int mode, input bit gaps);
    int eff;
    eff = (n == 0) ? 1 : n;
    do_start(n);
    for (int t = 0; t < eff; t++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      feed(rand_prod(), t == eff - 1);
    end
    drain(mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    prod_vec_t p;
    rst         = 1'b1;
    start       = 1'b0;
    prod_valid  = 1'b0;
    num_tiles   = '0;
    product_acc = '0;
    set_ready(1'b0);
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_lane", 32'(bus.out_lane), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
`ifdef TLUT_PSUM_SAT_EN
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // single tile with a few known lanes
    do_start(1);
    p = '0;
    p[0] = 13'd64;
    p[1] = 13'd81;
    p[2] = 13'd100;
    feed(p, 1'b1);
    drain(0);

    // three back-to-back full-scale tiles
    do_start(3);
    for (int t = 0; t < 3; t++) feed(all_max(), t == 2);
    drain(0);

    // backpressure, with a product arriving during DRAIN
    do_start(2);
    feed(rand_prod(), 1'b0);
    feed(rand_prod(), 1'b1);
    product_acc = rand_prod();
    prod_valid  = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("drain_drop_err", 32'(drop_err), 32'd1);
    drain(1);

    // product in IDLE
    product_acc = rand_prod();
    prod_valid  = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("idle_drop_err", 32'(drop_err), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // start and product together, then a stray start mid-ACCUM
    start       = 1'b1;
    num_tiles   = TILE_W'(2);
    product_acc = rand_prod();
    prod_valid  = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b0;
    clear_model();
    chk("same_cycle_drop_err", 32'(drop_err), 32'd0);
    chk("same_cycle_busy", 32'(busy), 32'd1);
    feed(rand_prod(), 1'b0);
    start     = 1'b1;
    num_tiles = TILE_W'(1);
    @(negedge clk);
    start = 1'b0;
    chk("restart_ignored_valid", 32'(bus.out_valid), 32'd0);
    feed(rand_prod(), 1'b1);
    drain(2);

    // reset after 2 of 4 tiles
    do_start(4);
    feed(rand_prod(), 1'b0);
    feed(rand_prod(), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midacc_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("midacc_rst_busy", 32'(busy), 32'd0);
    chk("midacc_rst_drop_err", 32'(drop_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(4, 0, 1'b0);

    // reset partway through a drain
    do_start(1);
    feed(rand_prod(), 1'b1);
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("middrain_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("middrain_rst_busy", 32'(busy), 32'd0);
    chk("middrain_rst_lane", 32'(bus.out_lane), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // two full-scale tiles overflow the 13-bit instance
    do_start(2);
    feed(all_max(), 1'b0);
    feed(all_max(), 1'b1);
    drain(0);

    // num_tiles of zero behaves as one
    run(0, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
